// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, synchronous imem reads, IF/ID register, one-entry skid buffer.
// Optional performance counters are enabled with the IFETCH_PERF_CNT_EN macro.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_rd_en,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
`ifdef IFETCH_PERF_CNT_EN
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count,
`endif
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STALL = 2'd2, FLUSH = 2'd3} state_t;

  state_t      state, n_state;
  logic [31:0] pc, n_pc, pc_inc;
  logic [31:0] ifid_instr, n_ifid_instr, ifid_pc4, n_ifid_pc4;
  logic        ifid_valid, n_ifid_valid;
  logic [31:0] skid_instr, n_skid_instr, skid_pc4, n_skid_pc4;
  logic        skid_valid, n_skid_valid;
  logic        rd_q;
  logic [31:0] rd_pc4;
  logic        rd_en, load_valid, redirect;
  logic [31:0] target;
  logic        unused_tgt_bits;

  assign pc_inc          = pc + 32'd4;
  assign redirect        = branch_taken | jump;
  assign target          = branch_taken ? {branch_target[31:2], 2'b00}
                                        : {ifid_pc4[31:28], jump_index, 2'b00};
  assign unused_tgt_bits = ^branch_target[1:0];

  // rd_q marks that imem_rdata this cycle answers a read issued last cycle.
  always_comb begin
    n_state      = state;
    n_pc         = pc;
    n_ifid_instr = ifid_instr;
    n_ifid_pc4   = ifid_pc4;
    n_ifid_valid = ifid_valid;
    n_skid_instr = skid_instr;
    n_skid_pc4   = skid_pc4;
    n_skid_valid = skid_valid;
    rd_en        = 1'b0;
    load_valid   = 1'b0;
    case (state)
      IDLE: n_state = RUN;
      RUN: begin
        rd_en        = 1'b1;
        n_pc         = pc_inc;
        n_ifid_valid = rd_q;
        load_valid   = rd_q;
        if (rd_q) begin
          n_ifid_instr = imem_rdata;
          n_ifid_pc4   = rd_pc4;
        end
        n_state = stall ? STALL : RUN;
      end
      STALL: begin
        if (!stall) begin
          // Release: drain the skid, or bypass a response that lands in a one-cycle stall.
          rd_en        = 1'b1;
          n_pc         = pc_inc;
          n_skid_valid = 1'b0;
          n_ifid_valid = skid_valid | rd_q;
          load_valid   = skid_valid | rd_q;
          if (skid_valid) begin
            n_ifid_instr = skid_instr;
            n_ifid_pc4   = skid_pc4;
          end else if (rd_q) begin
            n_ifid_instr = imem_rdata;
            n_ifid_pc4   = rd_pc4;
          end
          n_state = RUN;
        end else if (rd_q) begin
          n_skid_valid = 1'b1;
          n_skid_instr = imem_rdata;
          n_skid_pc4   = rd_pc4;
        end
      end
      FLUSH: begin
        rd_en        = 1'b1;
        n_pc         = pc_inc;
        n_ifid_valid = 1'b0;
        n_state      = stall ? STALL : RUN;
      end
      default: n_state = IDLE;
    endcase
    if (redirect && state != IDLE) begin
      n_pc         = target;
      n_ifid_instr = ifid_instr;
      n_ifid_pc4   = ifid_pc4;
      n_ifid_valid = 1'b0;
      n_skid_valid = 1'b0;
      load_valid   = 1'b0;
      n_state      = FLUSH;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      ifid_instr <= 32'h0;
      ifid_pc4   <= 32'h0;
      ifid_valid <= 1'b0;
      skid_instr <= 32'h0;
      skid_pc4   <= 32'h0;
      skid_valid <= 1'b0;
      rd_q       <= 1'b0;
      rd_pc4     <= 32'h0;
    end else begin
      state      <= n_state;
      pc         <= n_pc;
      ifid_instr <= n_ifid_instr;
      ifid_pc4   <= n_ifid_pc4;
      ifid_valid <= n_ifid_valid;
      skid_instr <= n_skid_instr;
      skid_pc4   <= n_skid_pc4;
      skid_valid <= n_skid_valid;
      rd_q       <= rd_en;
      if (rd_en) rd_pc4 <= pc_inc;
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count  <= 32'h0;
      bubble_count <= 32'h0;
    end else begin
      if (load_valid && fetch_count != 32'hFFFF_FFFF) fetch_count <= fetch_count + 32'd1;
      if (!ifid_valid && state != IDLE && bubble_count != 32'hFFFF_FFFF)
        bubble_count <= bubble_count + 32'd1;
    end
  end
`endif

  assign imem_addr   = pc;
  assign imem_rd_en  = rd_en;
  assign instr       = ifid_valid ? ifid_instr : 32'h0;
  assign opcode      = instr[31:26];
  assign pc_plus4    = ifid_pc4;
  assign instr_valid = ifid_valid;
  assign dbg_state   = state;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a per-cycle vector table plus a hand-written PC wrap sequence
// on a second instance built with RESET_PC = 32'hFFFF_FFF8.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, rst_w_n = 1'b0;
  logic        stall = 1'b0, branch_taken = 1'b0, jump = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [25:0] jump_index = 26'h0;

  logic [31:0] imem_addr, imem_rdata = 32'h0, instr, pc_plus4;
  logic        imem_rd_en, instr_valid;
  logic [5:0]  opcode;
  logic [1:0]  dbg_state;
  logic [31:0] w_addr, w_rdata = 32'h0, w_instr, w_pc4;
  logic        w_rd_en, w_valid;
  logic [5:0]  w_opcode;
  logic [1:0]  w_state;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_count, bubble_count, w_fetch_count, w_bubble_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_STALL = 2'd2, S_FLUSH = 2'd3;

  instr_fetch u_dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rd_en(imem_rd_en),
    .imem_rdata(imem_rdata), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_index(jump_index),
    .instr(instr), .opcode(opcode), .pc_plus4(pc_plus4), .instr_valid(instr_valid),
`ifdef IFETCH_PERF_CNT_EN
    .fetch_count(fetch_count), .bubble_count(bubble_count),
`endif
    .dbg_state(dbg_state)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst_n(rst_w_n), .imem_addr(w_addr), .imem_rd_en(w_rd_en),
    .imem_rdata(w_rdata), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_index(jump_index),
    .instr(w_instr), .opcode(w_opcode), .pc_plus4(w_pc4), .instr_valid(w_valid),
`ifdef IFETCH_PERF_CNT_EN
    .fetch_count(w_fetch_count), .bubble_count(w_bubble_count),
`endif
    .dbg_state(w_state)
  );

  // clock
  always #5 clk = ~clk;

  // instruction memory: word at byte address a is 32'h1000_0000 + a/4, one-cycle read latency
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= 32'h1000_0000 + (imem_addr >> 2);
    if (w_rd_en)    w_rdata    <= 32'h1000_0000 + (w_addr >> 2);
  end

  typedef struct {
    logic        rst_n, stall, br, jmp;
    logic [31:0] tgt;
    logic [25:0] jidx;
    logic        rd;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [1:0]  st;
  } vec_t;

  vec_t vt[27];

  function automatic vec_t mk(input logic r, input logic s, input logic b, input logic [31:0] t,
                              input logic j, input logic [25:0] ji, input logic rd,
                              input logic [31:0] a, input logic v, input logic [31:0] ins,
                              input logic [31:0] p4, input logic [1:0] st);
    vec_t x;
    x.rst_n = r; x.stall = s; x.br = b; x.tgt = t; x.jmp = j; x.jidx = ji;
    x.rd = rd; x.addr = a; x.valid = v; x.instr = ins; x.pc4 = p4; x.st = st;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_main(input int i, input vec_t v);
    logic [31:0] e;
    e = v.instr;
    chk($sformatf("v%0d rd_en", i), {31'b0, imem_rd_en}, {31'b0, v.rd});
    chk($sformatf("v%0d addr", i), imem_addr, v.addr);
    chk($sformatf("v%0d valid", i), {31'b0, instr_valid}, {31'b0, v.valid});
    chk($sformatf("v%0d instr", i), instr, e);
    chk($sformatf("v%0d opcode", i), {26'b0, opcode}, {26'b0, e[31:26]});
    chk($sformatf("v%0d pc_plus4", i), pc_plus4, v.pc4);
    chk($sformatf("v%0d state", i), {30'b0, dbg_state}, {30'b0, v.st});
  endtask

  initial begin
    //              rst stl br tgt          j  jidx      rd addr          v  instr         pc4           state
    vt[0]  = mk(0, 0, 0, 32'h0,  0, 26'h0,  0, 32'h0,   0, 32'h0,        32'h0,  S_IDLE);
    vt[1]  = mk(1, 0, 0, 32'h0,  0, 26'h0,  0, 32'h0,   0, 32'h0,        32'h0,  S_IDLE);
    vt[2]  = mk(1, 0, 0, 32'h0,  0, 26'h0,  1, 32'h0,   0, 32'h0,        32'h0,  S_RUN);
    vt[3]  = mk(1, 0, 0, 32'h0,  0, 26'h0,  1, 32'h4,   0, 32'h0,        32'h0,  S_RUN);
    vt[4]  = mk(1, 1, 0, 32'h0,  0, 26'h0,  1, 32'h8,   1, 32'h1000_0000, 32'h4,  S_RUN);
    vt[5]  = mk(1, 1, 0, 32'h0,  0, 26'h0,  0, 32'hC,   1, 32'h1000_0001, 32'h8,  S_STALL);
    vt[6]  = mk(1, 1, 0, 32'h0,  0, 26'h0,  0, 32'hC,   1, 32'h1000_0001, 32'h8,  S_STALL);
    vt[7]  = mk(1, 0, 0, 32'h0,  0, 26'h0,  1, 32'hC,   1, 32'h1000_0001, 32'h8,  S_STALL);
    vt[8]  = mk(1, 0, 0, 32'h0,  0, 26'h0,  1, 32'h10,  1, 32'h1000_0002, 32'hC,  S_RUN);
    vt[9]  = mk(1, 0, 0, 32'h0,  0, 26'h0,  1, 32'h14,  1, 32'h1000_0003, 32'h10, S_RUN);
    vt[10] = mk(1, 0, 1, 32'h43, 0, 26'h0,  1, 32'h18,  1, 32'h1000_0004, 32'h14, S_RUN);
    vt[11] = mk(1, 0, 0, 32'h0,  0, 26'h0,  1, 32'h40,  0, 32'h0,        32'h14, S_FLUSH);
    vt[12] = mk(1, 0, 0, 32'h0,  0, 26'h0,  1, 32'h44,  0, 32'h0,        32'h14, S_RUN);
    vt[13] = mk(1, 0, 1, 32'h80, 1, 26'h10, 1, 32'h48,  1, 32'h1000_0010, 32'h44, S_RUN);
    vt[14] = mk(1, 0, 0, 32'h0,  1, 26'h30, 1, 32'h80,  0, 32'h0,        32'h44, S_FLUSH);
    vt[15] = mk(1, 1, 0, 32'h0,  0, 26'h0,  1, 32'hC0,  0, 32'h0,        32'h44, S_FLUSH);
    vt[16] = mk(1, 1, 0, 32'h0,  0, 26'h0,  0, 32'hC4,  0, 32'h0,        32'h44, S_STALL);
    vt[17] = mk(1, 0, 0, 32'h0,  0, 26'h0,  1, 32'hC4,  0, 32'h0,        32'h44, S_STALL);
    vt[18] = mk(1, 1, 0, 32'h0,  0, 26'h0,  1, 32'hC8,  1, 32'h1000_0030, 32'hC4, S_RUN);
    vt[19] = mk(1, 1, 0, 32'h0,  0, 26'h0,  0, 32'hCC,  1, 32'h1000_0031, 32'hC8, S_STALL);
    vt[20] = mk(0, 1, 0, 32'h0,  0, 26'h0,  0, 32'hCC,  1, 32'h1000_0031, 32'hC8, S_STALL);
    vt[21] = mk(1, 1, 0, 32'h0,  0, 26'h0,  0, 32'h0,   0, 32'h0,        32'h0,  S_IDLE);
    vt[22] = mk(1, 0, 0, 32'h0,  0, 26'h0,  1, 32'h0,   0, 32'h0,        32'h0,  S_RUN);
    vt[23] = mk(1, 0, 0, 32'h0,  0, 26'h0,  1, 32'h4,   0, 32'h0,        32'h0,  S_RUN);
    vt[24] = mk(1, 1, 0, 32'h0,  0, 26'h0,  1, 32'h8,   1, 32'h1000_0000, 32'h4,  S_RUN);
    vt[25] = mk(1, 0, 0, 32'h0,  0, 26'h0,  1, 32'hC,   1, 32'h1000_0001, 32'h8,  S_STALL);
    vt[26] = mk(1, 0, 0, 32'h0,  0, 26'h0,  1, 32'h10,  1, 32'h1000_0002, 32'hC,  S_RUN);

    // reset preamble: two edges with rst_n low
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 27; i++) begin
      rst_n = vt[i].rst_n; stall = vt[i].stall; branch_taken = vt[i].br;
      branch_target = vt[i].tgt; jump = vt[i].jmp; jump_index = vt[i].jidx;
      @(negedge clk);
      vectors++;
      chk_main(i, vt[i]);
`ifdef IFETCH_PERF_CNT_EN
      if (i == 21) begin
        chk("fetch_count after reset", fetch_count, 32'd0);
        chk("bubble_count after reset", bubble_count, 32'd0);
      end
      if (i == 26) begin
        chk("fetch_count", fetch_count, 32'd3);
        chk("bubble_count", bubble_count, 32'd2);
      end
`endif
      @(posedge clk);
      #1;
    end

    // PC wrap on the RESET_PC = 32'hFFFF_FFF8 instance
    stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    rst_w_n = 1'b1;
    begin
      logic [31:0] e_addr[6];
      logic [31:0] e_instr[6];
      logic [31:0] e_pc4[6];
      logic        e_valid[6];
      e_addr  = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
      e_valid = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      e_instr = '{32'h0, 32'h0, 32'h0, 32'h4FFF_FFFE, 32'h4FFF_FFFF, 32'h1000_0000};
      e_pc4   = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h4};
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        vectors++;
        chk($sformatf("wrap c%0d addr", c), w_addr, e_addr[c]);
        chk($sformatf("wrap c%0d rd_en", c), {31'b0, w_rd_en}, {31'b0, (c != 0)});
        chk($sformatf("wrap c%0d valid", c), {31'b0, w_valid}, {31'b0, e_valid[c]});
        chk($sformatf("wrap c%0d instr", c), w_instr, e_instr[c]);
        chk($sformatf("wrap c%0d pc_plus4", c), w_pc4, e_pc4[c]);
        @(posedge clk);
        #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
